reg_file_sb: RTL and testbench

Parametrised register file with an integrated scoreboard, successor to the fixed 32x32 register file in the datapath. It provides two combinational read ports, one synchronous write port with optional write-to-read bypass, and an optional hardwired zero register. It adds per-register pending bits, so decode can stall on operands still owed by a multi-cycle producer. It sits between decode, which reads and claims registers, and writeback, which writes and releases them.

---
 rtl/reg_file_sb.sv | 126 ++++++++++++
 tb/tb_reg_file_sb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with per-register pending bits for operand scoreboarding.
// Ports: 2 comb read ports (+busy), 1 write port, 1 claim port, claim_err, pending_count.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  claim_enable,
  input  logic [ADDR_WIDTH-1:0] claim_reg,
  output logic                  claim_err,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;

  logic wr_zero;
  logic cl_zero;
  logic we_eff;
  logic cl_eff;
  logic same_rc;
  logic inc;
  logic dec;

  assign wr_zero = (ZERO_REG != 0) && (write_reg == '0);
  assign cl_zero = (ZERO_REG != 0) && (claim_reg == '0);
  assign we_eff  = write_enable & ~wr_zero;
  assign cl_eff  = claim_enable & ~cl_zero;
  assign same_rc = (write_reg == claim_reg);

  // Count tracks popcount: a claim of a free register adds one; a write
  // releases a pending register unless a new producer re-claims it.
  assign inc = cl_eff & ~pend_q[claim_reg];
  assign dec = we_eff & pend_q[write_reg] & ~(cl_eff & same_rc);

  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    count_d = count_q;
    if (we_eff) begin
      regs_d[write_reg] = write_data;
      pend_d[write_reg] = 1'b0;
    end
    // Claim applied after write so the new producer wins.
    if (cl_eff) begin
      pend_d[claim_reg] = 1'b1;
    end
    if (inc && !dec) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  logic byp1;
  logic byp2;
  logic z1;
  logic z2;

  assign byp1 = (BYPASS != 0) && write_enable && (write_reg == read_reg1);
  assign byp2 = (BYPASS != 0) && write_enable && (write_reg == read_reg2);
  assign z1   = (ZERO_REG != 0) && (read_reg1 == '0);
  assign z2   = (ZERO_REG != 0) && (read_reg2 == '0);

  always_comb begin
    read_data1 = regs_q[read_reg1];
    busy1      = pend_q[read_reg1];
    if (z1) begin
      read_data1 = '0;
      busy1      = 1'b0;
    end else if (byp1) begin
      read_data1 = write_data;
      busy1      = 1'b0;
    end
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
    busy2      = pend_q[read_reg2];
    if (z2) begin
      read_data2 = '0;
      busy2      = 1'b0;
    end else if (byp2) begin
      read_data2 = write_data;
      busy2      = 1'b0;
    end
  end

  assign claim_err = claim_enable & pend_q[claim_reg]
                   & ~(write_enable & same_rc);

  assign pending_count = count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scoreboard scenarios then random traffic
// against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic        busy1, busy2;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        claim_enable;
  logic [4:0]  claim_reg;
  logic        claim_err;
  logic [5:0]  pending_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic        mpend [32];

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .busy1(busy1), .busy2(busy2),
    .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data),
    .claim_enable(claim_enable), .claim_reg(claim_reg),
    .claim_err(claim_err), .pending_count(pending_count)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mclear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] e_rd(logic [4:0] r);
    if (r == 0) return '0;
    if (write_enable && write_reg == r) return write_data;
    return mregs[r];
  endfunction

  function automatic logic e_busy(logic [4:0] r);
    if (r == 0) return 1'b0;
    if (write_enable && write_reg == r) return 1'b0;
    return mpend[r];
  endfunction

  function automatic int e_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction

  task automatic idle_inputs();
    write_enable = 1'b0;
    write_reg    = '0;
    write_data   = '0;
    claim_enable = 1'b0;
    claim_reg    = '0;
  endtask

  task automatic step(string tag);
    logic e_err;
    #1;
    e_err = claim_enable && mpend[claim_reg]
          && !(write_enable && write_reg == claim_reg);
    chk({tag, ".rd1"}, read_data1, e_rd(read_reg1));
    chk({tag, ".rd2"}, read_data2, e_rd(read_reg2));
    chk({tag, ".busy1"}, 32'(busy1), 32'(e_busy(read_reg1)));
    chk({tag, ".busy2"}, 32'(busy2), 32'(e_busy(read_reg2)));
    chk({tag, ".cerr"}, 32'(claim_err), 32'(e_err));
    @(posedge clk);
    if (write_enable && write_reg != 0) begin
      mregs[write_reg] = write_data;
      mpend[write_reg] = 1'b0;
    end
    if (claim_enable && claim_reg != 0) mpend[claim_reg] = 1'b1;
    #1;
    chk({tag, ".cnt"}, 32'(pending_count), 32'(e_cnt()));
  endtask

  task automatic check_all_zero(string tag);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      chk({tag, ".rd1"}, read_data1, 32'h0);
      chk({tag, ".busy1"}, 32'(busy1), 32'h0);
    end
    chk({tag, ".cnt"}, 32'(pending_count), 32'h0);
  endtask

  initial begin
    mclear();
    rst = 1'b1;
    idle_inputs();
    read_reg1 = '0;
    read_reg2 = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check_all_zero("reset");

    // Fill some state, then async reset between edges.
    @(negedge clk);
    write_enable = 1; write_reg = 9; write_data = 32'h1234;
    claim_enable = 1; claim_reg = 11;
    step("pre");
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    mclear();
    read_reg1 = 9;
    #1;
    chk("async.rd", read_data1, 32'h0);
    chk("async.cnt", 32'(pending_count), 32'h0);
    rst = 1'b0;

    // Write 10 to r20, read next cycle.
    @(negedge clk);
    write_enable = 1; write_reg = 20; write_data = 32'd10;
    read_reg1 = 3; read_reg2 = 4;
    step("w20");
    idle_inputs();
    read_reg1 = 20; read_reg2 = 20;
    step("r20");

    // Bypass in write cycle.
    write_enable = 1; write_reg = 20; write_data = 32'hDEADBEEF;
    read_reg1 = 20; read_reg2 = 1;
    step("byp");
    idle_inputs();
    step("byp2");

    // Claim r5 then release via write.
    claim_enable = 1; claim_reg = 5; read_reg1 = 5;
    step("clm5");
    idle_inputs();
    step("busy5");
    write_enable = 1; write_reg = 5; write_data = 32'd7;
    step("wr5");
    idle_inputs();
    step("post5");

    // Double claim of r5.
    claim_enable = 1; claim_reg = 5;
    step("c5a");
    step("c5b");
    // Claim and write r6 together.
    idle_inputs();
    claim_enable = 1; claim_reg = 6;
    write_enable = 1; write_reg = 6; write_data = 32'h66;
    read_reg2 = 6;
    step("cw6");
    idle_inputs();
    step("chk6");
    // Claim and write r5 (pending) together: count unchanged.
    claim_enable = 1; claim_reg = 5;
    write_enable = 1; write_reg = 5; write_data = 32'h55;
    step("cw5");
    idle_inputs();

    // Zero register.
    write_enable = 1; write_reg = 0; write_data = 32'h55;
    claim_enable = 1; claim_reg = 0;
    read_reg1 = 0; read_reg2 = 0;
    step("z0");
    idle_inputs();
    claim_enable = 1; claim_reg = 0;
    step("z1");
    idle_inputs();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      write_enable = ($urandom_range(0, 99) < 45);
      write_reg    = 5'($urandom);
      write_data   = $urandom;
      claim_enable = ($urandom_range(0, 99) < 40);
      claim_reg    = ($urandom_range(0, 3) == 0) ? write_reg
                                                 : 5'($urandom);
      read_reg1    = ($urandom_range(0, 3) == 0) ? write_reg
                                                 : 5'($urandom);
      read_reg2    = ($urandom_range(0, 3) == 0) ? claim_reg
                                                 : 5'($urandom);
      step("rnd");
    end
    idle_inputs();

    // Fill r1..r31 from a clean state.
    rst = 1'b1;
    #1;
    mclear();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      claim_enable = 1; claim_reg = 5'(i);
      read_reg1 = 5'(i - 1);
      step("fill");
    end
    idle_inputs();
    chk("fill.max", 32'(pending_count), 32'd31);

    // Reset across an edge with a write in flight.
    write_enable = 1; write_reg = 3; write_data = 32'hCAFE;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mclear();
    check_all_zero("rstw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
